// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared helpers and parameter rules for the pipelined adder
package adder_pkg;

  // Bits added by each pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : 1;
  endfunction

  // WIDTH/STAGES combinations the skewed pipeline can be built for.
  function automatic bit params_legal(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/ha.sv
// rtl/ha.sv - single-bit half adder
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/rca_chunk.sv
// rtl/rca_chunk.sv - combinational W-bit ripple-carry adder built from half adders
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  // One full adder per bit: two half adders plus an OR for the carry.
  // Each bit keeps its own carry net so the chain is not one self-dependent vector.
  for (genvar i = 0; i < W; i++) begin : g_fa
    logic c_in;
    logic s1;
    logic c1;
    logic c2;
    logic c_out;

    if (i == 0) begin : g_lsb
      assign c_in = ci;
    end else begin : g_chain
      assign c_in = g_fa[i-1].c_out;
    end

    ha u_ha_ab (.a(a[i]), .b(b[i]), .s(s1),   .c(c1));
    ha u_ha_ci (.a(s1),   .b(c_in), .s(s[i]), .c(c2));

    assign c_out = c1 | c2;
  end

  assign co = g_fa[W-1].c_out;

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - skewed pipelined adder with carry-in/out, overflow and valid/ready
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_adder: WIDTH must be >= 2, 1 <= STAGES <= WIDTH, WIDTH divisible by STAGES");
  end

  // Whole pipe moves together; it only freezes when a result is waiting and not taken.
  logic en;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // Stage k consumes operand chunk k. Its slot carries the sum bits produced so far
  // plus only the operand bits still to be consumed, so slot widths shrink/grow along the pipe.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * CHUNK;
    localparam int HI  = LO + CHUNK;
    localparam int REM = WIDTH - HI;

    logic [WIDTH-LO-1:0] op_a;
    logic [WIDTH-LO-1:0] op_b;
    logic                ci;
    logic                vi;
    logic [CHUNK-1:0]    chunk_s;
    logic                chunk_c;
    logic [HI-1:0]       s_nxt;
    logic [HI-1:0]       s_q;
    logic                c_q;
    logic                v_q;

    if (k == 0) begin : g_head
      assign op_a  = a;
      assign op_b  = b;
      assign ci    = cin;
      assign vi    = in_valid;
      assign s_nxt = chunk_s;
    end else begin : g_body
      assign op_a  = g_stage[k-1].g_fwd.a_q;
      assign op_b  = g_stage[k-1].g_fwd.b_q;
      assign ci    = g_stage[k-1].c_q;
      assign vi    = g_stage[k-1].v_q;
      assign s_nxt = {chunk_s, g_stage[k-1].s_q};
    end

    rca_chunk #(.W(CHUNK)) u_rca (
      .a  (op_a[CHUNK-1:0]),
      .b  (op_b[CHUNK-1:0]),
      .ci (ci),
      .s  (chunk_s),
      .co (chunk_c)
    );

    // Partial sum, chunk carry and valid flag; bubbles shift like real data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (en) begin
        s_q <= s_nxt;
        c_q <= chunk_c;
        v_q <= vi;
      end
    end

    if (REM > 0) begin : g_fwd
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      // Operand bits above this chunk ride alongside for the later stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= op_a[WIDTH-LO-1:CHUNK];
          b_q <= op_b[WIDTH-LO-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // Last stage still sees both operand sign bits, so overflow is settled here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= (op_a[CHUNK-1] == op_b[CHUNK-1]) & (chunk_s[CHUNK-1] != op_a[CHUNK-1]);
        end
      end
    end
  end

  assign s         = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;
  assign out_valid = g_stage[STAGES-1].v_q;

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - directed and randomized bench for pipe_adder at depths 4, 1 and 16
module tb_pipe_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         in_valid;
  logic         out_ready;

  logic [W-1:0] s_o    [3];
  logic         cout_o [3];
  logic         ovf_o  [3];
  logic         ov_o   [3];
  logic         ir_o   [3];

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] exp_res [3][256];
  int          acc_cyc [3][256];
  int          acc_stl [3][256];
  int          wr  [3];
  int          rd  [3];
  int          stl [3];
  bit          hold [3];
  logic [17:0] held [3];

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .in_ready(ir_o[0]), .s(s_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]),
    .out_valid(ov_o[0]), .out_ready(out_ready)
  );

  pipe_adder #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .in_ready(ir_o[1]), .s(s_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]),
    .out_valid(ov_o[1]), .out_ready(out_ready)
  );

  pipe_adder #(.WIDTH(W), .STAGES(16)) u_s16 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .in_ready(ir_o[2]), .s(s_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2]),
    .out_valid(ov_o[2]), .out_ready(out_ready)
  );

  function automatic int depth_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
  endfunction

  // Reference: {ovf, cout, s} from plain integer arithmetic.
  function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
    int usum;
    int ssum;
    usum = int'(x) + int'(y) + int'(c);
    ssum = int'($signed(x)) + int'($signed(y)) + int'(c);
    return {(ssum > 32767) || (ssum < -32768), usum[16:0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (ov_o[d] !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %b want 0", d, ov_o[d]);
      else n_pass++;
      n_checks++;
      if ({ovf_o[d], cout_o[d], s_o[d]} !== 18'h0)
        $display("FAIL reset_outputs[%0d]: got %h want 0", d, {ovf_o[d], cout_o[d], s_o[d]});
      else n_pass++;
      n_checks++;
      if (ir_o[d] !== 1'b1) $display("FAIL reset_in_ready[%0d]: got %b want 1", d, ir_o[d]);
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (ir_o[0] !== 1'b1) $display("FAIL empty_in_ready: got %b want 1", ir_o[0]);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_ops();
    logic [15:0] x;
    logic [15:0] y;
    logic [17:0] want;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       begin x = 16'hFFFF; y = 16'h0001; want = {1'b0, 1'b1, 16'h0000}; end
        1:       begin x = 16'h7FFF; y = 16'h0001; want = {1'b1, 1'b0, 16'h8000}; end
        default: begin x = 16'h8000; y = 16'h8000; want = {1'b1, 1'b1, 16'h0000}; end
      endcase
      @(negedge clk);
      a = x; b = y; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_checks++;
      if (ir_o[0] !== 1'b1) $display("FAIL single_in_ready[%0d]: got %b want 1", t, ir_o[0]);
      else n_pass++;
      @(negedge clk);
      in_valid = 1'b0; a = 16'h5A5A; b = 16'hA5A5; cin = 1'b1;
      for (int n = 1; n <= 6; n++) begin
        #1;
        n_checks++;
        if (ov_o[0] !== (n == 4))
          $display("FAIL single_valid[%0d] cycle %0d: got %b want %b", t, n, ov_o[0], (n == 4));
        else n_pass++;
        if (n == 4) begin
          n_checks++;
          if ({ovf_o[0], cout_o[0], s_o[0]} !== want)
            $display("FAIL single_result[%0d]: got %h want %h", t, {ovf_o[0], cout_o[0], s_o[0]}, want);
          else n_pass++;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want;
    out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      if (n < 8) begin
        a = 16'(n); b = 16'(2 * n); cin = n[0]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_checks++;
      if (ir_o[0] !== 1'b1) $display("FAIL b2b_in_ready cycle %0d: got %b want 1", n, ir_o[0]);
      else n_pass++;
      n_checks++;
      if (ov_o[0] !== (n >= 4 && n < 12))
        $display("FAIL b2b_valid cycle %0d: got %b want %b", n, ov_o[0], (n >= 4 && n < 12));
      else n_pass++;
      if (n >= 4 && n < 12) begin
        want = 16'(3 * (n - 4) + ((n - 4) & 1));
        n_checks++;
        if (s_o[0] !== want || cout_o[0] !== 1'b0)
          $display("FAIL b2b_sum op %0d: got %h/%b want %h/0", n - 4, s_o[0], cout_o[0], want);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    int          sent;
    int          got;
    bit          saw_full;
    bit          hld;
    logic [17:0] hv;
    logic [15:0] want;
    sent = 0; got = 0; saw_full = 1'b0; hld = 1'b0; hv = '0;
    for (int n = 0; n < 40 && got < 8; n++) begin
      out_ready = !(n >= 5 && n <= 9);
      if (sent < 8) begin
        a = 16'(sent); b = 16'(2 * sent); cin = sent[0]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (hld) begin
        n_checks++;
        if (ov_o[0] !== 1'b1 || {ovf_o[0], cout_o[0], s_o[0]} !== hv)
          $display("FAIL stall_hold cycle %0d: got %b/%h want 1/%h", n, ov_o[0], {ovf_o[0], cout_o[0], s_o[0]}, hv);
        else n_pass++;
      end
      n_checks++;
      if (ir_o[0] !== (out_ready | ~ov_o[0]))
        $display("FAIL stall_in_ready cycle %0d: got %b want %b", n, ir_o[0], (out_ready | ~ov_o[0]));
      else n_pass++;
      if (n == 10) begin
        n_checks++;
        if (ir_o[0] !== 1'b1 || ov_o[0] !== 1'b1)
          $display("FAIL release_both_transfer: got in_ready %b out_valid %b want 1 1", ir_o[0], ov_o[0]);
        else n_pass++;
      end
      if (!ir_o[0]) saw_full = 1'b1;
      if (ov_o[0] === 1'b1 && out_ready) begin
        want = 16'(3 * got + (got & 1));
        n_checks++;
        if (s_o[0] !== want) $display("FAIL stall_order op %0d: got %h want %h", got, s_o[0], want);
        else n_pass++;
        got++;
      end
      hld = ov_o[0] && !out_ready;
      hv  = {ovf_o[0], cout_o[0], s_o[0]};
      if (in_valid && ir_o[0]) sent++;
      @(negedge clk);
    end
    n_checks++;
    if (got !== 8) $display("FAIL stall_delivered: got %0d want 8", got);
    else n_pass++;
    n_checks++;
    if (saw_full !== 1'b1) $display("FAIL stall_backpressure: got %b want 1", saw_full);
    else n_pass++;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      #1;
      n_checks++;
      if (ov_o[0] !== 1'b0) $display("FAIL stall_duplicate cycle %0d: got %b want 0", n, ov_o[0]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      a = 16'hF000 + 16'(n); b = 16'h1234; cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (ov_o[0] !== 1'b1 || {ovf_o[0], cout_o[0], s_o[0]} !== {1'b0, 1'b1, 16'h0234})
      $display("FAIL midreset_pre: got %b/%h want 1/%h", ov_o[0], {ovf_o[0], cout_o[0], s_o[0]}, {1'b0, 1'b1, 16'h0234});
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov_o[0] !== 1'b0 || {ovf_o[0], cout_o[0], s_o[0]} !== 18'h0)
      $display("FAIL midreset_async: got %b/%h want 0/0", ov_o[0], {ovf_o[0], cout_o[0], s_o[0]});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1;
      n_checks++;
      if (ov_o[0] !== 1'b0) $display("FAIL midreset_stale cycle %0d: got %b want 0", n, ov_o[0]);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int          cyc;
    int          drain;
    int          idx;
    int          lat;
    int          want_lat;
    logic [17:0] obs;
    logic        en_d;
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      wr[d] = 0; rd[d] = 0; stl[d] = 0; hold[d] = 1'b0; held[d] = '0;
    end
    cyc = 0; drain = -1;
    while (drain != 0 && cyc < 8000) begin
      if (drain < 0 && ((wr[0] >= 1000 && wr[1] >= 1000 && wr[2] >= 1000) || cyc >= 6000)) drain = 40;
      if (drain > 0) begin
        in_valid = 1'b0; out_ready = 1'b1; drain--;
      end else begin
        in_valid  = ($urandom_range(0, 9) < 8);
        out_ready = ($urandom_range(0, 3) != 0);
      end
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      #1;
      for (int d = 0; d < 3; d++) begin
        obs  = {ovf_o[d], cout_o[d], s_o[d]};
        en_d = out_ready | ~ov_o[d];
        if (hold[d]) begin
          n_checks++;
          if (ov_o[d] !== 1'b1 || obs !== held[d])
            $display("FAIL rand_hold[%0d] cycle %0d: got %b/%h want 1/%h", d, cyc, ov_o[d], obs, held[d]);
          else n_pass++;
        end
        n_checks++;
        if (ir_o[d] !== en_d) $display("FAIL rand_in_ready[%0d] cycle %0d: got %b want %b", d, cyc, ir_o[d], en_d);
        else n_pass++;
        if (ov_o[d] === 1'b1 && out_ready) begin
          n_checks++;
          if (rd[d] >= wr[d]) begin
            $display("FAIL rand_spurious[%0d] cycle %0d: got %h want none", d, cyc, obs);
          end else begin
            idx = rd[d] % 256;
            if (obs !== exp_res[d][idx])
              $display("FAIL rand_result[%0d] op %0d: got %h want %h", d, rd[d], obs, exp_res[d][idx]);
            else n_pass++;
            lat      = cyc - acc_cyc[d][idx];
            want_lat = depth_of(d) + stl[d] - acc_stl[d][idx];
            n_checks++;
            if (lat !== want_lat) $display("FAIL rand_latency[%0d] op %0d: got %0d want %0d", d, rd[d], lat, want_lat);
            else n_pass++;
            rd[d]++;
          end
        end
        if (!en_d) stl[d]++;
        hold[d] = ov_o[d] && !out_ready;
        held[d] = obs;
        if (in_valid && ir_o[d]) begin
          idx = wr[d] % 256;
          exp_res[d][idx] = ref_add(a, b, cin);
          acc_cyc[d][idx] = cyc;
          acc_stl[d][idx] = stl[d];
          wr[d]++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (rd[d] !== wr[d]) $display("FAIL rand_drain[%0d]: got %0d results want %0d", d, rd[d], wr[d]);
      else n_pass++;
      n_checks++;
      if (wr[d] < 1000) $display("FAIL rand_volume[%0d]: got %0d ops want >= 1000", d, wr[d]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
